// File: rtl/video_timing_pkg.sv
// Shared raster timing constants, FSM state type and registered flag bundle for video_timing_gen.
package video_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;
  localparam int unsigned DEF_CLK_DIV  = 2;
  localparam int unsigned DEF_CNT_W    = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vt_state_e;

  typedef struct packed {
    logic hs;
    logic vs;
    logic video_on;
    logic line_start;
    logic frame_start;
  } vt_flags_t;

  // Total positions in a line or frame: active + front porch + sync + back porch.
  function automatic int unsigned h_total(input int unsigned active, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned front,
                                          input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/video_timing_gen_pixel_tick_div.sv
// Pixel-rate divider: one-clock tick every CLK_DIV clocks while run is high, cleared when stopped.
module pixel_tick_div
  import video_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clock_50,
  input  logic reset_key,
  input  logic run,
  output logic tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (!run) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator with run/drain/park handshake and zero-skew registered outputs.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clock_50,
  input  logic             reset_key,
  input  logic             enable,
  output logic             running,
  output logic             p_tick,
  output logic             vga_hs,
  output logic             vga_vs,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  localparam vt_flags_t FLAGS_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, video_on: 1'b0,
                                       line_start: 1'b0, frame_start: 1'b0};

  // Reject configurations that cannot produce a legal raster.
  if (CLK_DIV < 1) begin : g_chk_div
    $error("video_timing_gen: CLK_DIV must be >= 1");
  end
  if (CNT_W < 1 || H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_chk_width
    $error("video_timing_gen: all intervals and CNT_W must be >= 1");
  end
  if (64'(H_TOTAL) > (64'd1 << CNT_W) || 64'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_chk_fit
    $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W");
  end

  vt_state_e        state, state_nxt;
  vt_flags_t        flags, flags_nxt;
  logic [CNT_W-1:0] x_nxt, y_nxt;
  logic [7:0]       fcount_nxt;
  logic             advance, h_wrap, f_wrap, running_nxt, div_run;

  // Divider restarts from zero each time the raster leaves IDLE and stops in the parking edge.
  assign div_run = running && running_nxt;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clock_50  (clock_50),
    .reset_key (reset_key),
    .run       (div_run),
    .tick      (p_tick)
  );

  always_comb begin
    state_nxt   = state;
    x_nxt       = pixel_x;
    y_nxt       = pixel_y;
    fcount_nxt  = frame_count;
    flags_nxt   = FLAGS_IDLE;
    advance     = (state != IDLE) && p_tick;
    h_wrap      = (pixel_x == H_LAST);
    f_wrap      = h_wrap && (pixel_y == V_LAST);

    // A drain re-raised exactly on the wrap tick keeps running rather than parking.
    unique case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)                 state_nxt = RUN;
        else if (advance && f_wrap) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (advance) begin
      if (h_wrap) begin
        x_nxt = '0;
        y_nxt = (pixel_y == V_LAST) ? '0 : pixel_y + 1'b1;
      end else begin
        x_nxt = pixel_x + 1'b1;
      end
      if (f_wrap) fcount_nxt = frame_count + 8'd1;
    end

    running_nxt = (state_nxt != IDLE);
    if (!running_nxt) begin
      x_nxt = '0;
      y_nxt = '0;
    end else begin
      flags_nxt.hs          = (x_nxt >= H_SYNC_BEG && x_nxt <= H_SYNC_END) ? HS_POL : ~HS_POL;
      flags_nxt.vs          = (y_nxt >= V_SYNC_BEG && y_nxt <= V_SYNC_END) ? VS_POL : ~VS_POL;
      flags_nxt.video_on    = (x_nxt < H_ACT) && (y_nxt < V_ACT);
      flags_nxt.line_start  = advance && h_wrap;
      flags_nxt.frame_start = advance && f_wrap;
    end
  end

  always_ff @(posedge clock_50 or negedge reset_key) begin
    if (!reset_key) begin
      state       <= IDLE;
      running     <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_count <= '0;
      flags       <= FLAGS_IDLE;
    end else begin
      state       <= state_nxt;
      running     <= running_nxt;
      pixel_x     <= x_nxt;
      pixel_y     <= y_nxt;
      frame_count <= fcount_nxt;
      flags       <= flags_nxt;
    end
  end

  assign vga_hs      = flags.hs;
  assign vga_vs      = flags.vs;
  assign video_on    = flags.video_on;
  assign line_start  = flags.line_start;
  assign frame_start = flags.frame_start;

endmodule
